insn_mem_ctrl: RTL and testbench
================================

# insn_mem_ctrl

Parametrised, handshake-driven instruction memory for a core. It accepts a program over a wide load bus, with several instructions per beat, under its own beat counter and load state machine. It then serves one-cycle-latency instruction fetches to the core's fetch stage. Loads may be shorter than the full depth, fetches beyond the loaded length are flagged, and an optional per-instruction parity check is available.

## Interface
Parameters:
- INSN_SIZE, 16, bits per instruction
- INSN_COUNT, 256, memory depth in instructions; must be a multiple of BUS_COUNT
- BUS_COUNT, 4, instructions per load beat
- derived: PTR_W = clog2(INSN_COUNT); BEATS = INSN_COUNT/BUS_COUNT; BEAT_W = clog2(BEATS+1)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse requesting a new program load
- load_beats  in  BEAT_W  beats to load, sampled with load_start; 0 or >BEATS means BEATS
- load_valid  in  1  load beat valid
- load_data  in  BUS_COUNT*INSN_SIZE  beat; slot j (bits (j+1)*INSN_SIZE-1 : j*INSN_SIZE) goes to address beat*BUS_COUNT+j
- load_ready  out  1  block accepts a beat
- load_busy  out  1  load in progress
- load_done  out  1  one-cycle pulse after the last beat is written
- mem_loaded  out  1  level; a complete program is resident
- rd_en  in  1  fetch request
- rd_ptr  in  PTR_W  fetch address
- rd_valid  out  1  fetch response valid
- rd_insn  out  INSN_SIZE  fetched instruction
- rd_oob  out  1  fetch was out of the loaded range, or issued while busy or unloaded
- rd_par_err  out  1  parity mismatch on this response (INSN_MEM_PARITY_EN only, else tied 0)

## Operation
- Reset values (async, on reset low):
  - state IDLE, load_ready 0, load_busy 0, load_done 0, mem_loaded 0
  - rd_valid 0, rd_insn 0, rd_oob 0, rd_par_err 0
  - beat counter 0, loaded_len 0
  - memory array not reset
- FSM states are IDLE, LOAD and DONE.
- IDLE:
  - load_start moves to LOAD; beats_target is latched from load_beats (clamped as above).
  - mem_loaded is cleared and the beat counter zeroed.
- LOAD:
  - load_ready = 1.
  - A beat is accepted when load_valid & load_ready. All BUS_COUNT slots are written at beat_cnt*BUS_COUNT+j, and beat_cnt increments.
  - Accepting the beat with beat_cnt == beats_target-1 moves to DONE.
  - load_start is ignored in LOAD.
- DONE (one cycle):
  - load_done = 1, mem_loaded := 1, loaded_len := beats_target*BUS_COUNT.
  - Returns to IDLE.
  - load_start in this cycle is ignored.
- load_busy = (state != IDLE).
- Fetch path:
  - rd_en in cycle N gives rd_valid = 1 in cycle N+1 with rd_insn = mem[rd_ptr].
  - rd_oob = 1 and rd_insn = 0 if any of: !mem_loaded, load_busy, rd_ptr >= loaded_len.
  - Without rd_en in cycle N, rd_valid = 0 in N+1 and rd_insn holds its value.
- Back-to-back fetches sustain one per cycle.
- Memory contents from a previous load persist past loaded_len but are never returned.

## Timing
- Fetch latency is 1 cycle, registered output.
- Load throughput is 1 beat/cycle when load_valid is held high. A full load takes beats_target+2 cycles from load_start to load_done: 1 to enter LOAD, beats_target accept cycles, then the DONE cycle.
- load_ready falls in the cycle after the last accepted beat.
- Reset falling mid-load:
  - Immediate return to IDLE; mem_loaded 0.
  - Partial contents are undefined-for-use: every fetch is oob until a new load completes.
- A fetch in the DONE cycle still returns oob, because mem_loaded updates at the end of DONE. The first valid fetch request is in the cycle after load_done.

## Configuration
- INSN_MEM_PARITY_EN defined:
  - Each stored word carries one extra even-parity bit, computed per slot on write.
  - A fetch recomputes parity and asserts rd_par_err with rd_valid on mismatch; rd_insn is still returned.
  - rd_par_err is 0 on oob responses.
- Undefined: no parity storage, rd_par_err constant 0.

## Structure
- Shared package insn_mem_pkg:
  - FSM state encoding (IDLE/LOAD/DONE)
  - defaults for INSN_SIZE/INSN_COUNT/BUS_COUNT
  - clog2-derived width constants
- One sub-module, insn_mem_load_fsm: state register, beat counter, beats_target/loaded_len, and handshake outputs. The top holds the array, write decode and fetch register.

## Test plan
- Full load: reset, load_start with load_beats=0, 64 beats of ascending words, then fetch 0, 5 and 255. Expect load_done at cycle 66 after start, rd_insn = 0x0000/0x0005/0x00FF, rd_oob 0.
- Partial load with stalls: load_beats=2, load_valid toggled every other cycle, then fetch ptr 7 and ptr 8. Expect only 2 beats accepted while load_ready stays 1, ptr 7 gives valid data, and ptr 8 gives rd_oob=1, rd_insn=0.
- Fetch while busy or unloaded: fetch before any load, and again during LOAD. Both give rd_valid=1, rd_oob=1, rd_insn=0.
- Reset mid-load: reset low after 10 beats. Expect all outputs at reset values and mem_loaded 0. A fresh 1-beat load then gives load_done and valid fetches at ptr 0..3.
- Reload and start-ignore: load_start pulsed during LOAD and DONE has no effect. A second load of 1 beat gives loaded_len=4, so ptr 4 is oob even though it was written by the first load.
- Parity (INSN_MEM_PARITY_EN): load, force-flip one stored bit at ptr 3, then fetch 3 and 2. Expect rd_par_err=1 for ptr 3 only.

Source files
------------

// File: rtl/insn_mem_pkg.sv
// Shared definitions for the instruction memory: load FSM encoding and default geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package insn_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    localparam int DEF_INSN_SIZE  = 16;
    localparam int DEF_INSN_COUNT = 256;
    localparam int DEF_BUS_COUNT  = 4;

    localparam int DEF_PTR_W  = $clog2(DEF_INSN_COUNT);
    localparam int DEF_BEATS  = DEF_INSN_COUNT / DEF_BUS_COUNT;
    localparam int DEF_BEAT_W = $clog2(DEF_BEATS + 1);

endpackage

// File: rtl/insn_mem_load_fsm.sv
// Program-load sequencer: IDLE/LOAD/DONE state, beat counter, load target and resident length.
// Latency: beats_target+2 cycles from load_start to the load_done pulse at one beat per cycle.
// Backpressure: load_ready is high for the whole LOAD state; beats are taken only on load_valid.
//
// Ports: clk/reset (async active-low); load_start/load_beats/load_valid in;
// load_ready/load_busy/load_done/mem_loaded handshake out; beat_wr/beat_idx drive the
// array write; loaded_len is the number of valid instructions after a completed load.
module insn_mem_load_fsm
    import insn_mem_pkg::*;
#(
    parameter int BUS_COUNT = DEF_BUS_COUNT,
    parameter int BEATS     = DEF_BEATS,
    parameter int BEAT_W    = DEF_BEAT_W,
    parameter int LEN_W     = DEF_PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [BEAT_W-1:0] load_beats,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              mem_loaded,
    output logic              beat_wr,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [LEN_W-1:0]  loaded_len
);

    localparam logic [BEAT_W-1:0] BEATS_MAX = BEAT_W'(BEATS);

    load_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0] target_q, target_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loaded_q, loaded_d;
    logic [BEAT_W-1:0] start_target;

    // A zero or oversize request means "fill the whole memory".
    always_comb begin
        start_target = load_beats;
        if (load_beats == '0 || load_beats > BEATS_MAX) begin
            start_target = BEATS_MAX;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        target_d   = target_q;
        len_d      = len_q;
        loaded_d   = loaded_q;
        beat_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    target_d   = start_target;
                    beat_cnt_d = '0;
                    loaded_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // load_ready is constant high here, so valid alone completes the handshake.
                if (load_valid) begin
                    beat_wr    = 1'b1;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == target_q - BEAT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                loaded_d = 1'b1;
                len_d    = LEN_W'(32'(target_q) * BUS_COUNT);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            target_q   <= '0;
            len_q      <= '0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            target_q   <= target_d;
            len_q      <= len_d;
            loaded_q   <= loaded_d;
        end
    end

    assign load_ready = (state_q == ST_LOAD);
    assign load_busy  = (state_q != ST_IDLE);
    assign load_done  = (state_q == ST_DONE);
    assign mem_loaded = loaded_q;
    assign beat_idx   = beat_cnt_q;
    assign loaded_len = len_q;

endmodule

// File: rtl/insn_mem_ctrl.sv
// Instruction memory: wide multi-instruction program load, single-instruction fetch port.
// Latency: fetch response registered, one cycle after rd_en; back-to-back fetches every cycle.
// Backpressure: load side via load_ready (high only in LOAD); the fetch side never stalls.
//
// Ports: clk/reset (async active-low); load_start/load_beats/load_valid/load_data and
// load_ready/load_busy/load_done/mem_loaded form the load interface; rd_en/rd_ptr request a
// fetch, answered by rd_valid/rd_insn/rd_oob/rd_par_err.
// Optional macro INSN_MEM_PARITY_EN adds one even-parity bit per stored word and drives
// rd_par_err; without it rd_par_err is tied low.
module insn_mem_ctrl
    import insn_mem_pkg::*;
#(
    parameter  int INSN_SIZE  = DEF_INSN_SIZE,
    parameter  int INSN_COUNT = DEF_INSN_COUNT,
    parameter  int BUS_COUNT  = DEF_BUS_COUNT,
    localparam int PTR_W      = $clog2(INSN_COUNT),
    localparam int BEATS      = INSN_COUNT / BUS_COUNT,
    localparam int BEAT_W     = $clog2(BEATS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_start,
    input  logic [BEAT_W-1:0]              load_beats,
    input  logic                           load_valid,
    input  logic [BUS_COUNT*INSN_SIZE-1:0] load_data,
    output logic                           load_ready,
    output logic                           load_busy,
    output logic                           load_done,
    output logic                           mem_loaded,
    input  logic                           rd_en,
    input  logic [PTR_W-1:0]               rd_ptr,
    output logic                           rd_valid,
    output logic [INSN_SIZE-1:0]           rd_insn,
    output logic                           rd_oob,
    output logic                           rd_par_err
);

    localparam int LEN_W = PTR_W + 1;

    logic              beat_wr;
    logic [BEAT_W-1:0] beat_idx;
    logic [LEN_W-1:0]  loaded_len;
    logic [PTR_W-1:0]  wr_base;

    insn_mem_load_fsm #(
        .BUS_COUNT (BUS_COUNT),
        .BEATS     (BEATS),
        .BEAT_W    (BEAT_W),
        .LEN_W     (LEN_W)
    ) u_load_fsm (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_beats (load_beats),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .mem_loaded (mem_loaded),
        .beat_wr    (beat_wr),
        .beat_idx   (beat_idx),
        .loaded_len (loaded_len)
    );

    // Storage is deliberately not reset; validity is tracked by mem_loaded/loaded_len.
    logic [INSN_SIZE-1:0] mem [INSN_COUNT];
`ifdef INSN_MEM_PARITY_EN
    logic                 mem_par [INSN_COUNT];
`endif

    assign wr_base = PTR_W'(32'(beat_idx) * BUS_COUNT);

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            for (int j = 0; j < BUS_COUNT; j++) begin
                mem[wr_base + PTR_W'(j)] <= load_data[j*INSN_SIZE +: INSN_SIZE];
`ifdef INSN_MEM_PARITY_EN
                mem_par[wr_base + PTR_W'(j)] <= ^load_data[j*INSN_SIZE +: INSN_SIZE];
`endif
            end
        end
    end

    logic [INSN_SIZE-1:0] fetch_word;
    logic                 fetch_oob;
    logic                 fetch_par_bad;

    assign fetch_word = mem[rd_ptr];
    // Busy covers the DONE cycle too, so a fetch there is refused even though the data is in.
    assign fetch_oob  = !mem_loaded || load_busy || ({1'b0, rd_ptr} >= loaded_len);

`ifdef INSN_MEM_PARITY_EN
    assign fetch_par_bad = ^{mem_par[rd_ptr], fetch_word};
`else
    assign fetch_par_bad = 1'b0;
`endif

    logic                 rd_valid_q, rd_valid_d;
    logic [INSN_SIZE-1:0] rd_insn_q, rd_insn_d;
    logic                 rd_oob_q, rd_oob_d;
    logic                 rd_par_q, rd_par_d;

    // Without a request, valid/oob/par_err drop but the last instruction is held.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_insn_d  = rd_insn_q;
        rd_oob_d   = 1'b0;
        rd_par_d   = 1'b0;
        if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_oob_d   = fetch_oob;
            rd_insn_d  = fetch_oob ? '0 : fetch_word;
            rd_par_d   = !fetch_oob && fetch_par_bad;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_insn_q  <= '0;
            rd_oob_q   <= 1'b0;
            rd_par_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_insn_q  <= rd_insn_d;
            rd_oob_q   <= rd_oob_d;
            rd_par_q   <= rd_par_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_insn    = rd_insn_q;
    assign rd_oob     = rd_oob_q;
`ifdef INSN_MEM_PARITY_EN
    assign rd_par_err = rd_par_q;
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_insn_mem_ctrl.sv
// Directed bench for insn_mem_ctrl with default geometry (16-bit words, 256 deep, 4 per beat).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_insn_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [6:0]  load_beats;
    logic        load_valid;
    logic [63:0] load_data;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        mem_loaded;
    logic        rd_en;
    logic [7:0]  rd_ptr;
    logic        rd_valid;
    logic [15:0] rd_insn;
    logic        rd_oob;
    logic        rd_par_err;

    int n_checks = 0;
    int n_fail   = 0;

    insn_mem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_beats (load_beats),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .mem_loaded (mem_loaded),
        .rd_en      (rd_en),
        .rd_ptr     (rd_ptr),
        .rd_valid   (rd_valid),
        .rd_insn    (rd_insn),
        .rd_oob     (rd_oob),
        .rd_par_err (rd_par_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input logic [15:0] base, input int b);
        logic [63:0] d;
        for (int j = 0; j < 4; j++) begin
            d[j*16 +: 16] = base + 16'(b * 4 + j);
        end
        return d;
    endfunction

    // Cycle 1 is the load_start cycle; returns the cycle number in which load_done is seen.
    task automatic do_load(input int beats_req, input logic [15:0] base, input bit stall,
                           input int abort_after, output int done_cyc, output int accepted,
                           output int ready_low);
        int  cyc;
        bit  acc;
        done_cyc   = -1;
        accepted   = 0;
        ready_low  = 0;
        load_start = 1'b1;
        load_beats = 7'(beats_req);
        load_valid = 1'b0;
        step();
        load_start = 1'b0;
        cyc = 2;
        while (cyc < 300) begin
            if (load_done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_after > 0 && accepted == abort_after) break;
            if (!load_ready) ready_low++;
            load_valid = stall ? cyc[0] : 1'b1;
            load_data  = beat_data(base, accepted);
            acc = load_valid && load_ready;
            step();
            if (acc) accepted++;
            cyc++;
        end
        load_valid = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [7:0] ptr, input logic [15:0] exp_insn,
                             input bit exp_oob, input bit exp_par);
        rd_en  = 1'b1;
        rd_ptr = ptr;
        step();
        rd_en  = 1'b0;
        check_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_val({tag, "_insn"}, 32'(rd_insn), 32'(exp_insn));
        check_val({tag, "_oob"}, 32'(rd_oob), 32'(exp_oob));
        check_val({tag, "_par"}, 32'(rd_par_err), 32'(exp_par));
    endtask

    initial begin
        int done_cyc, accepted, ready_low;
        reset      = 1'b0;
        load_start = 1'b0;
        load_beats = '0;
        load_valid = 1'b0;
        load_data  = '0;
        rd_en      = 1'b0;
        rd_ptr     = '0;

        // Reset values
        step();
        step();
        check_val("rst_load_ready", 32'(load_ready), 0);
        check_val("rst_load_busy", 32'(load_busy), 0);
        check_val("rst_load_done", 32'(load_done), 0);
        check_val("rst_mem_loaded", 32'(mem_loaded), 0);
        check_val("rst_rd_valid", 32'(rd_valid), 0);
        check_val("rst_rd_insn", 32'(rd_insn), 0);
        check_val("rst_rd_oob", 32'(rd_oob), 0);
        check_val("rst_rd_par", 32'(rd_par_err), 0);
        reset = 1'b1;
        step();

        // Fetch before any load
        fetch_chk("unloaded", 8'd0, 16'h0000, 1'b1, 1'b0);
        step();
        check_val("idle_no_valid", 32'(rd_valid), 0);

        // Full load, ascending words
        do_load(0, 16'h0000, 1'b0, 0, done_cyc, accepted, ready_low);
        check_val("full_done_cyc", 32'(done_cyc), 32'd66);
        check_val("full_accepted", 32'(accepted), 32'd64);
        check_val("full_ready_low", 32'(ready_low), 0);
        check_val("done_mem_loaded", 32'(mem_loaded), 0);
        check_val("done_busy", 32'(load_busy), 1);
        // Fetch issued in the DONE cycle is refused
        fetch_chk("in_done", 8'd0, 16'h0000, 1'b1, 1'b0);
        check_val("post_mem_loaded", 32'(mem_loaded), 1);
        check_val("post_busy", 32'(load_busy), 0);
        check_val("post_done", 32'(load_done), 0);

        // Back-to-back fetches 0, 5, 255
        rd_en  = 1'b1;
        rd_ptr = 8'd0;
        step();
        check_val("b2b0_insn", 32'(rd_insn), 32'h0000);
        check_val("b2b0_oob", 32'(rd_oob), 0);
        rd_ptr = 8'd5;
        step();
        check_val("b2b5_insn", 32'(rd_insn), 32'h0005);
        check_val("b2b5_valid", 32'(rd_valid), 1);
        rd_ptr = 8'd255;
        step();
        check_val("b2b255_insn", 32'(rd_insn), 32'h00FF);
        check_val("b2b255_oob", 32'(rd_oob), 0);
        rd_en = 1'b0;
        step();
        check_val("hold_valid", 32'(rd_valid), 0);
        check_val("hold_insn", 32'(rd_insn), 32'h00FF);

        // Partial load of 2 beats with load_valid every other cycle
        do_load(2, 16'h1000, 1'b1, 0, done_cyc, accepted, ready_low);
        check_val("part_done_cyc", 32'(done_cyc), 32'd6);
        check_val("part_accepted", 32'(accepted), 32'd2);
        check_val("part_ready_low", 32'(ready_low), 0);
        step();
        fetch_chk("part_p7", 8'd7, 16'h1007, 1'b0, 1'b0);
        fetch_chk("part_p8", 8'd8, 16'h0000, 1'b1, 1'b0);

        // Fetch while busy, load_start ignored in LOAD and DONE, 1-beat reload
        load_start = 1'b1;
        load_beats = 7'd1;
        step();
        check_val("ld_ready", 32'(load_ready), 1);
        check_val("ld_busy", 32'(load_busy), 1);
        load_start = 1'b1;
        load_beats = 7'd5;
        rd_en      = 1'b1;
        rd_ptr     = 8'd0;
        step();
        load_start = 1'b0;
        rd_en      = 1'b0;
        check_val("busy_valid", 32'(rd_valid), 1);
        check_val("busy_oob", 32'(rd_oob), 1);
        check_val("busy_insn", 32'(rd_insn), 0);
        load_valid = 1'b1;
        load_data  = beat_data(16'h2000, 0);
        step();
        load_valid = 1'b0;
        check_val("rl_done", 32'(load_done), 1);
        check_val("rl_ready_fall", 32'(load_ready), 0);
        load_start = 1'b1;
        load_beats = 7'd3;
        step();
        load_start = 1'b0;
        check_val("rl_mem_loaded", 32'(mem_loaded), 1);
        step();
        check_val("rl_start_ignored", 32'(load_busy), 0);
        fetch_chk("rl_p0", 8'd0, 16'h2000, 1'b0, 1'b0);
        fetch_chk("rl_p3", 8'd3, 16'h2003, 1'b0, 1'b0);
        fetch_chk("rl_p4", 8'd4, 16'h0000, 1'b1, 1'b0);
        fetch_chk("rl_p3b", 8'd3, 16'h2003, 1'b0, 1'b0);

        // Reset asserted mid-load after 10 beats
        do_load(0, 16'h4000, 1'b0, 10, done_cyc, accepted, ready_low);
        check_val("abort_accepted", 32'(accepted), 32'd10);
        reset = 1'b0;
        #1;
        check_val("mrst_load_ready", 32'(load_ready), 0);
        check_val("mrst_load_busy", 32'(load_busy), 0);
        check_val("mrst_load_done", 32'(load_done), 0);
        check_val("mrst_mem_loaded", 32'(mem_loaded), 0);
        check_val("mrst_rd_valid", 32'(rd_valid), 0);
        check_val("mrst_rd_insn", 32'(rd_insn), 0);
        check_val("mrst_rd_oob", 32'(rd_oob), 0);
        step();
        reset = 1'b1;
        step();
        fetch_chk("mrst_fetch", 8'd1, 16'h0000, 1'b1, 1'b0);

        // Fresh 1-beat load, back-to-back fetch 0..3
        do_load(1, 16'h3000, 1'b0, 0, done_cyc, accepted, ready_low);
        check_val("fresh_done_cyc", 32'(done_cyc), 32'd3);
        step();
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_ptr = 8'(i);
            step();
            check_val("fresh_insn", 32'(rd_insn), 32'h3000 + 32'(i));
            check_val("fresh_oob", 32'(rd_oob), 0);
        end
        rd_en = 1'b0;
        fetch_chk("fresh_p4", 8'd4, 16'h0000, 1'b1, 1'b0);

`ifdef INSN_MEM_PARITY_EN
        // Corrupt one stored bit at ptr 3
        dut.mem[3] = dut.mem[3] ^ 16'h0001;
        fetch_chk("par_p3", 8'd3, 16'h3002, 1'b0, 1'b1);
        fetch_chk("par_p2", 8'd2, 16'h3002, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
